// File: rtl/text_reveal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_reveal_ctrl
// Purpose  : Drives the shared glyph renderer to draw one of four fixed banner
//            messages with a typewriter-style letter reveal, then optionally
//            blinks the complete message.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            x, y              - current VGA pixel column / row
//            frame_tick        - one pulse per frame (reveal/blink timebase)
//            start, clear      - begin reveal of msg_sel / blank and go idle
//            msg_sel, blink_en - message index (sampled on start), blink enable
//            select_char       - glyph code for this pixel's cell (31 = blank)
//            posx, posy        - cell origin, zero-extended to 32 bits
//            char_en           - pixel may be lit (ANDed with glyph downstream)
//            reveal_count      - letters currently revealed
//            busy, done        - revealing / message fully shown
// Revision : 1.0 - initial release
// ============================================================================
module text_reveal_ctrl #(
  parameter int BASE_X       = 100,
  parameter int BASE_Y       = 50,
  parameter int REVEAL_TICKS = 2,
  parameter int BLINK_TICKS  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        clear,
  input  logic [1:0]  msg_sel,
  input  logic        blink_en,
  output logic [4:0]  select_char,
  output logic [31:0] posx,
  output logic [31:0] posy,
  output logic        char_en,
  output logic [3:0]  reveal_count,
  output logic        busy,
  output logic        done
);

  localparam int TW = (REVEAL_TICKS > 1) ? $clog2(REVEAL_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TW-1:0] REV_LAST   = TW'(REVEAL_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [4:0]    BLANK      = 5'd31;

  typedef enum logic [1:0] {IDLE = 2'd0, REVEAL = 2'd1, SHOW = 2'd2} state_t;

  state_t        state;
  logic [1:0]    msg;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  logic          visible;

  // Glyph codes: S=0 T=1 R=2 G=3 A=4 M=5 H=6 I=7 O=8 V=9
  function automatic logic [4:0] rom_code(input logic [1:0] m, input logic [2:0] i);
    logic [4:0] c;
    c = BLANK;
    case (m)
      2'd0: case (i)           // START
              3'd0: c = 5'd0;
              3'd1: c = 5'd1;
              3'd2: c = 5'd4;
              3'd3: c = 5'd2;
              3'd4: c = 5'd1;
              default: c = BLANK;
            endcase
      2'd1: case (i)           // GO
              3'd0: c = 5'd3;
              3'd1: c = 5'd8;
              default: c = BLANK;
            endcase
      2'd2: case (i)           // HI
              3'd0: c = 5'd6;
              3'd1: c = 5'd7;
              default: c = BLANK;
            endcase
      default: case (i)        // VS
              3'd0: c = 5'd9;
              3'd1: c = 5'd0;
              default: c = BLANK;
            endcase
    endcase
    return c;
  endfunction

  function automatic logic [3:0] msg_len(input logic [1:0] m);
    return (m == 2'd0) ? 4'd5 : 4'd2;
  endfunction

  logic [3:0] rc_next;
  assign rc_next = reveal_count + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      msg          <= 2'd0;
      reveal_count <= 4'd0;
      tick_cnt     <= '0;
      blink_cnt    <= '0;
      visible      <= 1'b1;
    end else if (clear) begin
      state        <= IDLE;
      reveal_count <= 4'd0;
      tick_cnt     <= '0;
      blink_cnt    <= '0;
      visible      <= 1'b1;
    end else if (start) begin
      // Restart from any state; a coincident frame_tick is deliberately dropped.
      state        <= REVEAL;
      msg          <= msg_sel;
      reveal_count <= 4'd0;
      tick_cnt     <= '0;
      blink_cnt    <= '0;
      visible      <= 1'b1;
    end else begin
      case (state)
        REVEAL: begin
          if (frame_tick) begin
            if (tick_cnt == REV_LAST) begin
              tick_cnt     <= '0;
              reveal_count <= rc_next;
              if (rc_next == msg_len(msg)) state <= SHOW;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        SHOW: begin
          if (!blink_en) begin
            visible   <= 1'b1;
            blink_cnt <= '0;
          end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              visible   <= ~visible;
            end else begin
              blink_cnt <= blink_cnt + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == REVEAL);
  assign done = (state == SHOW);

  // Pixel path. 11-bit arithmetic keeps x < BASE_X from wrapping into the text.
  logic [10:0] x_ext, y_ext, dx;
  logic [6:0]  idx;
  logic [3:0]  off;
  logic        in_row, in_region;

  assign x_ext     = {1'b0, x};
  assign y_ext     = {1'b0, y};
  assign dx        = x_ext - 11'(BASE_X);
  assign idx       = dx[10:4];
  assign off       = dx[3:0];
  assign in_row    = (y_ext >= 11'(BASE_Y)) && (y_ext <= 11'(BASE_Y + 19));
  assign in_region = (x_ext >= 11'(BASE_X)) && ({3'b000, msg_len(msg)} > idx) && in_row;

  assign select_char = in_region ? rom_code(msg, idx[2:0]) : BLANK;
  assign posx        = in_region ? (32'(BASE_X) + {21'd0, idx, 4'd0}) : 32'd0;
  assign posy        = in_region ? 32'(BASE_Y) : 32'd0;
  // Columns 10..15 of each cell are inter-letter gap.
  assign char_en     = in_region && (off <= 4'd9) && ({3'b000, reveal_count} > idx)
                       && visible && (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_text_reveal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_reveal_ctrl
// Purpose  : Directed vector bench for text_reveal_ctrl (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_reveal_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0, y = '0;
  logic        frame_tick = 1'b0, start = 1'b0, clear = 1'b0, blink_en = 1'b0;
  logic [1:0]  msg_sel = '0;
  logic [4:0]  select_char;
  logic [31:0] posx, posy;
  logic        char_en, busy, done;
  logic [3:0]  reveal_count;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  text_reveal_ctrl dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
    .start(start), .clear(clear), .msg_sel(msg_sel), .blink_en(blink_en),
    .select_char(select_char), .posx(posx), .posy(posy), .char_en(char_en),
    .reveal_count(reveal_count), .busy(busy), .done(done)
  );

  typedef struct {
    logic       rst, st, cl, ft;
    logic [1:0] ms;
    logic       be;
    logic [9:0] vx, vy;
    logic       cp;            // check pixel address fields
    logic [4:0] sc;
    logic [31:0] px, py;
    logic       ce;
    logic [3:0] rc;
    logic       bu, dn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, st, cl, ft, input logic [1:0] ms, input logic be,
                     input logic [9:0] vx, vy, input logic cp, input logic [4:0] sc,
                     input logic [31:0] px, py, input logic ce, input logic [3:0] rc,
                     input logic bu, dn);
    vec_t v;
    v.rst = rst; v.st = st; v.cl = cl; v.ft = ft; v.ms = ms; v.be = be;
    v.vx = vx; v.vy = vy; v.cp = cp; v.sc = sc; v.px = px; v.py = py;
    v.ce = ce; v.rc = rc; v.bu = bu; v.dn = dn;
    tbl.push_back(v);
  endtask

  // Drive inputs for one clock, then sample 1 time unit after the edge.
  task automatic drive(input logic rst, st, cl, ft, input logic [1:0] ms, input logic be,
                       input logic [9:0] vx, vy);
    @(negedge clk);
    reset = rst; start = st; clear = cl; frame_tick = ft; msg_sel = ms; blink_en = be;
    x = vx; y = vy;
    @(posedge clk);
    #1;
  endtask

  // Move the pixel without a clock edge.
  task automatic probe(input logic [9:0] vx, vy);
    x = vx; y = vy;
    #1;
  endtask

  task automatic chk(input string nm, input logic cp, input logic [4:0] sc,
                     input logic [31:0] px, py, input logic ce, input logic [3:0] rc,
                     input logic bu, dn);
    applied++;
    if (cp && select_char !== sc) begin
      miscompares++; $display("FAIL %s select_char got %0d exp %0d", nm, select_char, sc);
    end
    if (cp && posx !== px) begin
      miscompares++; $display("FAIL %s posx got %0d exp %0d", nm, posx, px);
    end
    if (cp && posy !== py) begin
      miscompares++; $display("FAIL %s posy got %0d exp %0d", nm, posy, py);
    end
    if (char_en !== ce) begin
      miscompares++; $display("FAIL %s char_en got %b exp %b", nm, char_en, ce);
    end
    if (reveal_count !== rc) begin
      miscompares++; $display("FAIL %s reveal_count got %0d exp %0d", nm, reveal_count, rc);
    end
    if (busy !== bu) begin
      miscompares++; $display("FAIL %s busy got %b exp %b", nm, busy, bu);
    end
    if (done !== dn) begin
      miscompares++; $display("FAIL %s done got %b exp %b", nm, done, dn);
    end
  endtask

  initial begin
    //   rst st cl ft ms be  x    y   cp sc   px   py ce rc bu dn
    // reset and idle
    add(1, 0, 0, 0, 0, 0, 100, 50,  0, 31,   0,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 100, 50,  0, 31,   0,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 100, 50,  0, 31,   0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 100, 50,  0, 31,   0,  0, 0, 0, 0, 0);
    // start "START", reveal: one letter per 2 ticks
    add(0, 1, 0, 0, 0, 0,   0,  0,  1, 31,   0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 105, 55,  1,  0, 100, 50, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 105, 55,  1,  0, 100, 50, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 117, 55,  1,  1, 116, 50, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,   0,  0,  1, 31,   0,  0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,   0,  0,  1, 31,   0,  0, 0, 2, 1, 0);
    add(0, 0, 0, 1, 0, 0,   0,  0,  1, 31,   0,  0, 0, 2, 1, 0);
    add(0, 0, 0, 1, 0, 0,   0,  0,  1, 31,   0,  0, 0, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0,   0,  0,  1, 31,   0,  0, 0, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0,   0,  0,  1, 31,   0,  0, 0, 4, 1, 0);
    add(0, 0, 0, 1, 0, 0,   0,  0,  1, 31,   0,  0, 0, 4, 1, 0);
    add(0, 0, 0, 1, 0, 0, 164, 60,  1,  1, 164, 50, 1, 5, 0, 1);
    // SHOW: region boundaries
    add(0, 0, 0, 0, 0, 0, 110, 55,  1,  0, 100, 50, 0, 5, 0, 1);
    add(0, 0, 0, 0, 0, 0, 180, 55,  1, 31,   0,  0, 0, 5, 0, 1);
    add(0, 0, 0, 0, 0, 0, 105, 70,  1, 31,   0,  0, 0, 5, 0, 1);
    add(0, 0, 0, 0, 0, 0,  99, 55,  1, 31,   0,  0, 0, 5, 0, 1);
    add(0, 0, 0, 0, 0, 0, 179, 69,  1,  1, 164, 50, 0, 5, 0, 1);
    add(0, 0, 0, 0, 0, 0, 109, 69,  1,  0, 100, 50, 1, 5, 0, 1);
    add(0, 0, 0, 0, 0, 0, 109, 49,  1, 31,   0,  0, 0, 5, 0, 1);
    // blink: half period 3 ticks
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 1, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 1, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 0, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 0, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 0, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 1, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 1, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 1, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 0, 5, 0, 1);
    // drop blink_en: visible restored, blink count cleared
    add(0, 0, 0, 0, 0, 0, 105, 55,  1,  0, 100, 50, 1, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 1, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 1, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 105, 55,  1,  0, 100, 50, 0, 5, 0, 1);
    add(0, 0, 0, 0, 0, 0, 105, 55,  1,  0, 100, 50, 1, 5, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].cl, tbl[i].ft, tbl[i].ms, tbl[i].be,
            tbl[i].vx, tbl[i].vy);
      chk($sformatf("vec%0d", i), tbl[i].cp, tbl[i].sc, tbl[i].px, tbl[i].py,
          tbl[i].ce, tbl[i].rc, tbl[i].bu, tbl[i].dn);
    end

    // Restart mid-reveal: msg 0 to reveal_count 3, then start msg 2 with a tick.
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 0, 0, 0, 0);
    chk("rst_pre", 1, 31, 0, 0, 0, 3, 1, 0);
    drive(0, 1, 0, 1, 2, 0, 0, 0);
    chk("restart", 1, 31, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    chk("restart_t1", 1, 31, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    chk("restart_t2", 1, 31, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 117, 55);
    chk("hi_done", 1, 7, 116, 50, 1, 2, 0, 1);
    probe(133, 55);
    chk("hi_past_end", 1, 31, 0, 0, 0, 2, 0, 1);

    // clear beats start in SHOW.
    drive(0, 1, 1, 0, 1, 0, 105, 55);
    chk("clr_start", 1, 6, 100, 50, 0, 0, 0, 0);
    probe(117, 60);
    chk("clr_x117", 1, 7, 116, 50, 0, 0, 0, 0);
    probe(109, 69);
    chk("clr_x109", 1, 6, 100, 50, 0, 0, 0, 0);

    // Reset mid-reveal of "GO".
    drive(0, 1, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 105, 55);
    chk("go_rc1", 1, 3, 100, 50, 1, 1, 1, 0);
    drive(1, 0, 0, 1, 0, 0, 105, 55);
    chk("mid_reset", 1, 0, 100, 50, 0, 0, 0, 0);
    probe(164, 60);
    chk("reset_msg0", 1, 1, 164, 50, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
